shiftreg_deser: RTL and testbench

SHIFTREG_DESER -- requirements
Module: shiftreg_deser

---
 rtl/shiftreg_pkg.sv | 15 +
 rtl/shiftreg_shift_core.sv | 43 ++++
 rtl/shiftreg_deser.sv | 150 +++++++++++++++
 tb/tb_shiftreg_deser.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_pkg.sv
// Shared encodings for the serial-to-parallel deserializer: FSM states and
// bit-order selection.
package shiftreg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef enum logic {
    DIR_MSB_FIRST = 1'b0,
    DIR_LSB_FIRST = 1'b1
  } dir_e;

endpackage

// File: rtl/shiftreg_shift_core.sv
// WIDTH-bit directional shift register; a load-clear shift starts a new word
// from an all-zero register with the incoming bit as its first bit.
module shiftreg_shift_core
  import shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_clr,
  input  logic             i_shift_en,
  input  dir_e             i_dir,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_word
);

  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_base = i_load_clr ? '0 : r_word;
    w_next = w_base;
    case (i_dir)
      DIR_MSB_FIRST: w_next = {w_base[WIDTH-2:0], i_sin};
      DIR_LSB_FIRST: w_next = {i_sin, w_base[WIDTH-1:1]};
      default:       w_next = w_base;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word <= '0;
    end else if (i_shift_en) begin
      r_word <= w_next;
    end else if (i_load_clr) begin
      r_word <= '0;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/shiftreg_deser.sv
// Framed serial-to-parallel deserializer with a one-entry output holding
// register and sticky overrun / framing-error flags.
module shiftreg_deser
  import shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             SIN,
  input  logic             SIN_VALID,
  input  logic             FRAME,
  input  logic             DIR,
  input  logic             CLR_ERR,
  input  logic             DOUT_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic             FRAME_ERR
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  dir_e             r_dir;
  dir_e             w_dir_nxt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;
  logic             r_frame_err;

  logic             w_load_clr;
  logic             w_shift_en;
  logic             w_done;
  logic             w_ferr_evt;
  logic             w_load;
  logic             w_ovr_evt;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_done_word;

  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_dir   <= DIR_MSB_FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_load_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    w_ferr_evt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (SIN_VALID && FRAME) begin
          w_load_clr  = 1'b1;
          w_shift_en  = 1'b1;
          w_dir_nxt   = dir_e'(DIR);
          w_count_nxt = CW'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (SIN_VALID) begin
          w_shift_en = 1'b1;
          // A new FRAME restarts the word even on what would be its last bit.
          if (FRAME) begin
            w_ferr_evt  = 1'b1;
            w_load_clr  = 1'b1;
            w_dir_nxt   = dir_e'(DIR);
            w_count_nxt = CW'(1);
          end else if (r_count == LAST) begin
            w_done      = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  shiftreg_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk     (CLOCK),
    .i_rst     (CLEAR),
    .i_load_clr(w_load_clr),
    .i_shift_en(w_shift_en),
    .i_dir     (w_dir_nxt),
    .i_sin     (SIN),
    .o_word    (w_word)
  );

  // The holding register captures the word as it stands after the final shift,
  // so it is formed here rather than waiting a cycle for the core to settle.
  always_comb begin
    w_done_word = w_word;
    case (r_dir)
      DIR_MSB_FIRST: w_done_word = {w_word[WIDTH-2:0], SIN};
      DIR_LSB_FIRST: w_done_word = {SIN, w_word[WIDTH-1:1]};
      default:       w_done_word = w_word;
    endcase
  end

  always_comb begin
    w_load    = w_done && (!r_dout_valid || DOUT_READY);
    w_ovr_evt = w_done && !w_load;
  end

  always_ff @(posedge CLOCK or posedge CLEAR) begin
    if (CLEAR) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (w_load) begin
        r_dout       <= w_done_word;
        r_dout_valid <= 1'b1;
      end else if (DOUT_READY) begin
        r_dout_valid <= 1'b0;
      end
      r_overrun   <= (r_overrun & ~CLR_ERR) | w_ovr_evt;
      r_frame_err <= (r_frame_err & ~CLR_ERR) | w_ferr_evt;
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = r_dout_valid;
  assign BUSY       = (r_state == ST_SHIFT);
  assign OVERRUN    = r_overrun;
  assign FRAME_ERR  = r_frame_err;

endmodule

// File: tb/tb_shiftreg_deser.sv
// Directed bench for shiftreg_deser (WIDTH=8); inputs change and outputs are
// sampled on the falling clock edge.
module tb_shiftreg_deser;

  logic       CLOCK = 1'b0;
  logic       CLEAR = 1'b1;
  logic       SIN = 1'b0;
  logic       SIN_VALID = 1'b0;
  logic       FRAME = 1'b0;
  logic       DIR = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       DOUT_READY = 1'b0;
  logic [7:0] DOUT;
  logic       DOUT_VALID;
  logic       BUSY;
  logic       OVERRUN;
  logic       FRAME_ERR;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  shiftreg_deser #(
    .WIDTH(8)
  ) dut (
    .CLOCK     (CLOCK),
    .CLEAR     (CLEAR),
    .SIN       (SIN),
    .SIN_VALID (SIN_VALID),
    .FRAME     (FRAME),
    .DIR       (DIR),
    .CLR_ERR   (CLR_ERR),
    .DOUT_READY(DOUT_READY),
    .DOUT      (DOUT),
    .DOUT_VALID(DOUT_VALID),
    .BUSY      (BUSY),
    .OVERRUN   (OVERRUN),
    .FRAME_ERR (FRAME_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic b, input logic fr);
    SIN       = b;
    FRAME     = fr;
    SIN_VALID = 1'b1;
    @(negedge CLOCK);
    SIN_VALID = 1'b0;
    FRAME     = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge CLOCK);
  endtask

  // seq[7] is sent first; flip toggles DIR mid-word (must be ignored).
  task automatic send_word(input logic [7:0] seq, input logic d,
                           input int unsigned gap, input bit flip);
    DIR = d;
    for (int i = 0; i < 8; i++) begin
      send(seq[7-i], logic'(i == 0));
      if (flip && i == 3) DIR = ~d;
      if (gap != 0 && i < 7) idle(gap);
    end
    DIR = d;
  endtask

  task automatic pulse_clr_err();
    CLR_ERR = 1'b1;
    @(negedge CLOCK);
    CLR_ERR = 1'b0;
  endtask

  initial begin
    idle(2);
    check("rst_dout", DOUT, 8'h00);
    check("rst_valid", 8'(DOUT_VALID), 8'd0);
    check("rst_busy", 8'(BUSY), 8'd0);
    check("rst_ovr", 8'(OVERRUN), 8'd0);
    check("rst_ferr", 8'(FRAME_ERR), 8'd0);
    CLEAR = 1'b0;
    idle(1);

    // Unframed bits in IDLE are ignored.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check("idle_ignore_busy", 8'(BUSY), 8'd0);
    check("idle_ignore_valid", 8'(DOUT_VALID), 8'd0);

    // MSB-first, consumer always ready.
    DOUT_READY = 1'b1;
    DIR = 1'b0;
    send(1'b1, 1'b1);
    check("busy_after_frame", 8'(BUSY), 8'd1);
    for (int i = 0; i < 7; i++) send(logic'(i == 0), 1'b0);
    check("msb_dout", DOUT, 8'hC0);
    check("msb_valid", 8'(DOUT_VALID), 8'd1);
    check("msb_busy_done", 8'(BUSY), 8'd0);
    idle(1);
    check("msb_valid_drop", 8'(DOUT_VALID), 8'd0);

    // LSB-first, then LSB-first with gaps and a mid-word DIR change.
    send_word(8'b1100_0000, 1'b1, 0, 1'b0);
    check("lsb_dout", DOUT, 8'h03);
    check("lsb_valid", 8'(DOUT_VALID), 8'd1);
    idle(1);
    send_word(8'b1100_0000, 1'b1, 2, 1'b1);
    check("lsb_gap_dout", DOUT, 8'h03);
    check("lsb_gap_valid", 8'(DOUT_VALID), 8'd1);
    idle(1);

    // Overrun: second word dropped while holding register is full.
    DOUT_READY = 1'b0;
    send_word(8'hC0, 1'b0, 0, 1'b0);
    check("ovr_first_dout", DOUT, 8'hC0);
    check("ovr_first_flag", 8'(OVERRUN), 8'd0);
    send_word(8'h3C, 1'b0, 0, 1'b0);
    check("ovr_hold_dout", DOUT, 8'hC0);
    check("ovr_hold_valid", 8'(DOUT_VALID), 8'd1);
    check("ovr_flag", 8'(OVERRUN), 8'd1);
    pulse_clr_err();
    check("ovr_cleared", 8'(OVERRUN), 8'd0);
    check("ovr_dout_stable", DOUT, 8'hC0);

    // Drain and load on the same edge.
    DIR = 1'b0;
    send(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(logic'(i % 2 == 0), 1'b0);
    DOUT_READY = 1'b1;
    send(1'b0, 1'b0);
    check("same_edge_dout", DOUT, 8'h54);
    check("same_edge_valid", 8'(DOUT_VALID), 8'd1);
    check("same_edge_ovr", 8'(OVERRUN), 8'd0);
    idle(1);
    check("same_edge_drain", 8'(DOUT_VALID), 8'd0);

    // FRAME after 3 bits: restart with the second FRAME as bit 1.
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    DIR = 1'b0;
    send(1'b1, 1'b1);
    check("ferr_flag", 8'(FRAME_ERR), 8'd1);
    check("ferr_busy", 8'(BUSY), 8'd1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    check("ferr_no_early_word", 8'(DOUT_VALID), 8'd0);
    send(1'b0, 1'b0);
    check("ferr_dout", DOUT, 8'h96);
    check("ferr_valid", 8'(DOUT_VALID), 8'd1);
    pulse_clr_err();
    check("ferr_cleared", 8'(FRAME_ERR), 8'd0);

    // FRAME on the completing bit, with CLR_ERR on the same edge.
    send(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
    CLR_ERR = 1'b1;
    send(1'b1, 1'b1);
    CLR_ERR = 1'b0;
    check("ferr_last_flag", 8'(FRAME_ERR), 8'd1);
    check("ferr_last_nowrd", 8'(DOUT_VALID), 8'd0);
    check("ferr_last_busy", 8'(BUSY), 8'd1);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("ferr_last_dout", DOUT, 8'h81);
    pulse_clr_err();

    // CLEAR mid-word, then a clean word.
    DOUT_READY = 1'b0;
    send_word(8'h3C, 1'b0, 0, 1'b0);
    send(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
    CLEAR = 1'b1;
    #1;
    check("clr_dout", DOUT, 8'h00);
    check("clr_valid", 8'(DOUT_VALID), 8'd0);
    check("clr_busy", 8'(BUSY), 8'd0);
    check("clr_ovr", 8'(OVERRUN), 8'd0);
    check("clr_ferr", 8'(FRAME_ERR), 8'd0);
    @(negedge CLOCK);
    CLEAR = 1'b0;
    idle(1);
    send_word(8'hA5, 1'b0, 0, 1'b0);
    check("post_clr_dout", DOUT, 8'hA5);
    check("post_clr_valid", 8'(DOUT_VALID), 8'd1);
    check("post_clr_ferr", 8'(FRAME_ERR), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
